// File: rtl/centipede_pkg.sv
// Shared definitions for the playfield RAM arbiter.
// Address width, arbiter states and default stall limit.
package centipede_pkg;

   localparam int PF_AW         = 10;
   localparam int MAX_STALL_DEF = 4;

   typedef enum logic {
      IDLE     = 1'b0,
      CPU_DONE = 1'b1
   } arb_state_t;

endpackage

// File: rtl/arb_stall_counter.sv
// Counts consecutive lost CPU arbitration cycles.
// Saturates at MAX and flags when the limit is reached.
module arb_stall_counter
   import centipede_pkg::*;
#(
   parameter int MAX = MAX_STALL_DEF
) (
   input  logic clk,
   input  logic rst_l,
   input  logic inc,
   input  logic clr,
   output logic sat
);

   localparam int CW = (MAX < 1) ? 1 : $clog2(MAX + 1);
   localparam logic [CW-1:0] TOP = CW'(MAX);

   logic [CW-1:0] cnt;

   // count lost cycles, clear on issue or when the CPU leaves
   always_ff @(posedge clk) begin
      if (!rst_l || clr)
         cnt <= '0;
      else if (inc && (cnt != TOP))
         cnt <= cnt + 1'b1;
   end

   assign sat = (cnt == TOP);

endmodule

// File: rtl/pf_ram_arbiter.sv
// Shares one synchronous playfield RAM between the 6502 and
// the graphics tile fetcher, with a bounded CPU stall.
module pf_ram_arbiter
   import centipede_pkg::*;
#(
   parameter int AW        = PF_AW,
   parameter int MAX_STALL = MAX_STALL_DEF
) (
   input  logic          clk,
   input  logic          rst_l,
   input  logic          cpu_sel,
   input  logic [AW-1:0] cpu_addr,
   input  logic          cpu_we_l,
   input  logic [7:0]    cpu_wdata,
   output logic [7:0]    cpu_rdata,
   output logic          cpu_rdy,
   input  logic          vblank,
   input  logic          gp_req,
   input  logic [AW-1:0] gp_addr,
   output logic          gp_gnt,
   output logic [7:0]    gp_rdata,
   output logic          gp_rvalid,
   output logic [AW-1:0] ram_addr,
   output logic          ram_we,
   output logic [7:0]    ram_wdata,
   input  logic [7:0]    ram_rdata
);

   arb_state_t state;
   arb_state_t state_nxt;

   logic       cpu_pend;
   logic       gp_pend;
   logic       cpu_win;
   logic       gp_win;
   logic       sat;
   logic       stall_inc;
   logic       stall_clr;
   logic       rd_q;
   logic       gp_rd_q;
   logic       done_rd;
   logic [7:0] rdata_q;

   // nothing is pending while reset is held, so nothing issues
   assign cpu_pend = rst_l && cpu_sel && (state != CPU_DONE);
   assign gp_pend  = rst_l && gp_req;

   // graphics has priority outside vblank until the CPU starves
   assign cpu_win = cpu_pend && (!gp_pend || vblank || sat);
   assign gp_win  = gp_pend && !cpu_win;

   assign stall_inc = cpu_pend && !cpu_win;
   assign stall_clr = cpu_win || !cpu_sel;

   arb_stall_counter #(
      .MAX (MAX_STALL)
   ) u_stall (
      .clk   (clk),
      .rst_l (rst_l),
      .inc   (stall_inc),
      .clr   (stall_clr),
      .sat   (sat)
   );

   // state register
   always_ff @(posedge clk) begin
      if (!rst_l)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // next state: a CPU issue is always followed by one completion cycle
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:     if (cpu_win) state_nxt = CPU_DONE;
         CPU_DONE: state_nxt = IDLE;
      endcase
   end

   // RAM port steering, grant and CPU ready
   always_comb begin
      ram_addr  = gp_addr;
      ram_we    = 1'b0;
      ram_wdata = 8'h00;
      gp_gnt    = gp_win;
      cpu_rdy   = !rst_l || !cpu_sel || (state == CPU_DONE);
      if (cpu_win) begin
         ram_addr  = cpu_addr;
         ram_we    = !cpu_we_l;
         ram_wdata = cpu_wdata;
      end
   end

   // remember what was issued so the returning data can be routed
   always_ff @(posedge clk) begin
      if (!rst_l) begin
         rd_q    <= 1'b0;
         gp_rd_q <= 1'b0;
         rdata_q <= 8'h00;
      end else begin
         rd_q    <= cpu_win && cpu_we_l;
         gp_rd_q <= gp_win;
         if (done_rd)
            rdata_q <= ram_rdata;
      end
   end

   // read data is passed straight through in the completion cycle
   // and held from the register afterwards
   assign done_rd   = rst_l && (state == CPU_DONE) && rd_q;
   assign cpu_rdata = done_rd ? ram_rdata : rdata_q;

   assign gp_rvalid = rst_l && gp_rd_q;
   assign gp_rdata  = ram_rdata;

endmodule

// File: doc/pf_ram_arbiter.md
PF_RAM_ARBITER -- requirements
Module: pf_ram_arbiter

Interface
REQ-001 Parameter AW, default 10: playfield RAM address width.
REQ-002 Parameter MAX_STALL, default 4: maximum consecutive cycles a pending CPU access may lose arbitration.
REQ-003 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 Port rst_l, input, 1: reset, synchronous and active-low.
REQ-005 Port cpu_sel, input, 1: address decoder selects playfield RAM for the current 6502 bus cycle.
REQ-006 Port cpu_addr, input, AW: CPU word address.
REQ-007 Port cpu_we_l, input, 1: 0 = write, 1 = read.
REQ-008 Port cpu_wdata, input, 8: CPU write data.
REQ-009 Port cpu_rdata, output, 8: CPU read data.
REQ-010 Port cpu_rdy, output, 1: drives 6502 RDY; 0 = stall.
REQ-011 Port vblank, input, 1: vertical blank from the graphics pipeline.
REQ-012 Port gp_req, input, 1: graphics tile-fetch read request.
REQ-013 Port gp_addr, input, AW: graphics read address.
REQ-014 Port gp_gnt, output, 1: graphics request issued this cycle.
REQ-015 Port gp_rdata, output, 8: graphics read data.
REQ-016 Port gp_rvalid, output, 1: gp_rdata valid this cycle.
REQ-017 Ports ram_addr (out, AW), ram_we (out, 1), ram_wdata (out, 8), ram_rdata (in, 8): single-port synchronous RAM, read data one cycle after the address.

Function
REQ-018 Each cycle, exactly one access at most SHALL be issued on ram_*; ram_we SHALL be 1 only for an issued CPU write.
REQ-019 CPU pending = cpu_sel=1 and the arbiter is not in the CPU completion cycle; GP pending = gp_req=1.
REQ-020 Only one pending: that requester SHALL be issued.
REQ-021 Both pending: GP SHALL win when vblank=0, CPU SHALL win when vblank=1, except CPU SHALL win whenever stall_cnt = MAX_STALL.
REQ-022 stall_cnt SHALL increment each cycle the CPU is pending and not issued, saturate at MAX_STALL, and clear on CPU issue or cpu_sel=0.
REQ-023 States: IDLE, CPU_DONE; CPU issue moves IDLE->CPU_DONE; CPU_DONE always returns to IDLE next cycle.
REQ-024 cpu_rdy SHALL be 1 when cpu_sel=0 or in CPU_DONE, and 0 otherwise.
REQ-025 In CPU_DONE after a read, cpu_rdata SHALL equal ram_rdata, and SHALL be registered and held until the next CPU read completes.
REQ-026 A GP request SHALL be issued in CPU_DONE if pending, so completion and a GP issue overlap.
REQ-027 gp_gnt SHALL be 1 combinationally in the GP issue cycle; gp_rvalid SHALL be 1 exactly one cycle later with gp_rdata = ram_rdata.
REQ-028 Back-to-back GP requests SHALL sustain one read per cycle when the CPU is not pending.
REQ-029 A CPU write SHALL have minimum latency issue -> cpu_rdy=1 next cycle; reads likewise, with data.
REQ-030 An address change on cpu_addr while stalled SHALL take effect; the address sampled in the issue cycle is the one used.

Reset
REQ-031 While rst_l=0 at a clock edge: state=IDLE, stall_cnt=0, cpu_rdata=0, gp_rvalid=0 next cycle, ram_we=0, gp_gnt=0.
REQ-032 A read in flight when reset asserts SHALL be discarded: no gp_rvalid and no cpu_rdata update.
REQ-033 During reset, cpu_rdy SHALL be 1 and no RAM access SHALL issue.

Structure
REQ-034 centipede_pkg SHALL hold PF_AW, the arbiter state enum (IDLE, CPU_DONE), and the default MAX_STALL.
REQ-035 The stall counter SHALL be a sub-module, arb_stall_counter (inputs inc, clr; output sat); all else is flat RTL.

Verification
REQ-036 Reset with gp_req=1 -> gp_gnt=0, ram_we=0, cpu_rdy=1; after release, gp_gnt=1 on the first cycle.
REQ-037 CPU write 0x3C to 0x155, no GP traffic -> ram_we=1, ram_addr=0x155 in cycle N; cpu_rdy=0 in N and 1 in N+1.
REQ-038 vblank=1 with simultaneous CPU read of 0x020 and GP read of 0x021 -> CPU issued first; GP gnt in the CPU_DONE cycle; cpu_rdata correct one cycle after CPU issue.
REQ-039 vblank=0 with continuous gp_req and a CPU read pending -> CPU issued on the 5th cycle (stall_cnt=4), GP resumes in CPU_DONE, gp_rvalid never duplicated or lost.
REQ-040 Continuous GP reads 0x000..0x00F -> 16 gnt in 16 cycles, gp_rvalid each following cycle with matching data.
REQ-041 rst_l=0 one cycle after a GP issue -> no gp_rvalid; state=IDLE.
